// File: rtl/spr_line_eval_if.sv
// spr_line_eval_if
//   Bundles the two buses of the sprite line evaluator.
//   Attribute fetch: spr_sel (evaluator -> attribute RAM/regs) and the
//     combinational reply spr_y / spr_enable / spr_h16 / spr_vflip.
//   Hit-list stream: out_valid / out_sel / out_line (evaluator -> consumer)
//     with out_ready as backpressure.
//   master: the evaluator side.  slave: attribute store + list consumer.
interface spr_line_eval_if #(
    parameter int SEL_W = 6
);
    logic [SEL_W-1:0] spr_sel;
    logic [7:0]       spr_y;
    logic             spr_enable;
    logic             spr_h16;
    logic             spr_vflip;

    logic             out_valid;
    logic             out_ready;
    logic [SEL_W-1:0] out_sel;
    logic [3:0]       out_line;

    modport master (
        output spr_sel,
        input  spr_y, spr_enable, spr_h16, spr_vflip,
        output out_valid, out_sel, out_line,
        input  out_ready
    );

    modport slave (
        input  spr_sel,
        output spr_y, spr_enable, spr_h16, spr_vflip,
        input  out_valid, out_sel, out_line,
        output out_ready
    );
endinterface

// File: rtl/spr_line_eval.sv
// spr_line_eval
//   Per-video-line sprite evaluator. On start it scans every sprite slot,
//   one per cycle, collects up to MAX_PER_LINE sprites that cover the line
//   (with the pattern row to fetch), then streams that list out.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start, vline   one-cycle kick-off pulse and the video line it is for
//   bus (master)   attribute fetch (spr_sel -> attributes, same cycle) and
//                  the out_valid/out_ready hit-list stream
//   count          entries stored for the current line
//   overflow       more sprites hit than the list could hold
//   busy           scan or drain in progress
//   done           one-cycle pulse when the list has been fully drained
module spr_line_eval #(
    parameter int NUM_SPRITES  = 64,
    parameter int SEL_W        = 6,
    parameter int MAX_PER_LINE = 16,
    parameter int CNT_W        = 5,
    parameter int LINE_OFFSET  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       vline,
    spr_line_eval_if.master  bus,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rd_q, rd_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       line_idx_q, line_idx_d;
    logic [SEL_W-1:0] ent_sel_q  [MAX_PER_LINE];
    logic [SEL_W-1:0] ent_sel_d  [MAX_PER_LINE];
    logic [3:0]       ent_line_q [MAX_PER_LINE];
    logic [3:0]       ent_line_d [MAX_PER_LINE];

    // Hit test for the sprite currently addressed by sel_q. The 8-bit
    // modular difference makes sprites straddling line 255->0 hit naturally.
    logic [7:0] ydiff;
    logic [3:0] h;
    logic       hit;
    logic [3:0] row;

    always_comb begin
        ydiff = line_idx_q - bus.spr_y;
        h     = bus.spr_h16 ? 4'd15 : 4'd7;
        hit   = (state_q == SCAN) && bus.spr_enable && (ydiff <= {4'd0, h});
        row   = bus.spr_vflip ? (h - ydiff[3:0]) : ydiff[3:0];
    end

    // rd_q never passes cnt_q, so equality means the list is exhausted.
    logic has_entry;
    logic drained;
    assign has_entry = (state_q == DRAIN) && (rd_q < cnt_q);
    assign drained   = (state_q == DRAIN) && (rd_q == cnt_q);

    logic [SEL_W-1:0] rd_sel;
    logic [3:0]       rd_line;

    always_comb begin
        rd_sel  = '0;
        rd_line = '0;
        for (int i = 0; i < MAX_PER_LINE; i++) begin
            if (rd_q == CNT_W'(i)) begin
                rd_sel  = ent_sel_q[i];
                rd_line = ent_line_q[i];
            end
        end
    end

    assign bus.spr_sel   = sel_q;
    assign bus.out_valid = has_entry;
    // Zeroed when nothing is presented so the bus reads clean in IDLE/reset.
    assign bus.out_sel   = has_entry ? rd_sel  : '0;
    assign bus.out_line  = has_entry ? rd_line : '0;
    assign count         = cnt_q;
    assign overflow      = ovf_q;
    // done is the drained DRAIN cycle; busy drops in that same cycle.
    assign done          = drained;
    assign busy          = (state_q == SCAN) || has_entry;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        ovf_d      = ovf_q;
        line_idx_d = line_idx_q;
        ent_sel_d  = ent_sel_q;
        ent_line_d = ent_line_q;

        if (start) begin
            // Restart from any state; an in-flight list is simply dropped
            // and a pending handshake is not honoured.
            state_d    = SCAN;
            sel_d      = '0;
            cnt_d      = '0;
            rd_d       = '0;
            ovf_d      = 1'b0;
            line_idx_d = vline - 8'(LINE_OFFSET);
        end else begin
            case (state_q)
                IDLE: ;
                SCAN: begin
                    if (hit) begin
                        if (cnt_q == CNT_W'(MAX_PER_LINE)) begin
                            ovf_d = 1'b1;
                        end else begin
                            for (int i = 0; i < MAX_PER_LINE; i++) begin
                                if (cnt_q == CNT_W'(i)) begin
                                    ent_sel_d[i]  = sel_q;
                                    ent_line_d[i] = row;
                                end
                            end
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    if (sel_q == SEL_W'(NUM_SPRITES - 1)) begin
                        state_d = DRAIN;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state_d = IDLE;
                    end else if (bus.out_ready) begin
                        rd_d = rd_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // List storage is only meaningful below cnt_q, so it needs no reset.
        ent_sel_q  <= ent_sel_d;
        ent_line_q <= ent_line_d;
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            ovf_q      <= 1'b0;
            line_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            ovf_q      <= ovf_d;
            line_idx_q <= line_idx_d;
        end
    end
endmodule

// File: doc/spr_line_eval.md
SPR_LINE_EVAL -- requirements
Module: spr_line_eval

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 64: number of sprite attribute slots scanned per line.
REQ-002 SHALL have parameter SEL_W, default 6: width of sprite select; 2**SEL_W >= NUM_SPRITES.
REQ-003 SHALL have parameter MAX_PER_LINE, default 16: capacity of the per-line hit list, 1..NUM_SPRITES.
REQ-004 SHALL have parameter CNT_W, default 5: width of count; 2**CNT_W > MAX_PER_LINE.
REQ-005 SHALL have parameter LINE_OFFSET, default 15: subtracted from vline to form the sprite-space line index.
REQ-006 clk  input  1  clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse; begins evaluation for vline.
REQ-009 vline  input  8  current video line, sampled on start.
REQ-010 spr_sel  output  SEL_W  sprite attribute select; attributes below are combinational from it in the same cycle.
REQ-011 spr_y  input  8  selected sprite Y.
REQ-012 spr_enable  input  1  selected sprite enabled.
REQ-013 spr_h16  input  1  selected sprite is 16 lines tall (else 8).
REQ-014 spr_vflip  input  1  selected sprite vertically flipped.
REQ-015 out_valid  output  1  hit-list entry available.
REQ-016 out_ready  input  1  consumer accepts entry.
REQ-017 out_sel  output  SEL_W  sprite index of current entry.
REQ-018 out_line  output  4  pattern row within sprite, vflip applied.
REQ-019 count  output  CNT_W  number of entries stored for the current line.
REQ-020 overflow  output  1  more than MAX_PER_LINE sprites hit current line.
REQ-021 busy  output  1  scan or drain in progress.
REQ-022 done  output  1  one-cycle pulse when list fully drained.

Function
REQ-023 SHALL implement states IDLE, SCAN, DRAIN.
REQ-024 start in any state SHALL, next cycle: state=SCAN, spr_sel=0, count=0, read pointer=0, overflow=0, latch line_idx=(vline-LINE_OFFSET) mod 256; any in-progress scan/drain is abandoned, no done pulse.
REQ-025 SCAN SHALL evaluate exactly one sprite per cycle at spr_sel, then increment spr_sel; scan lasts exactly NUM_SPRITES cycles regardless of hits.
REQ-026 Hit rule: ydiff=(line_idx-spr_y) mod 256; h=15 if spr_h16 else 7; hit iff spr_enable and ydiff<=h (vertical wrap through 255->0 is thereby supported).
REQ-027 Hit entry SHALL be {spr_sel, vflip ? h-ydiff[3:0] : ydiff[3:0]} (4-bit result), appended in ascending sprite index order.
REQ-028 Hit with count==MAX_PER_LINE SHALL NOT be stored and SHALL set overflow=1 (sticky until next start/reset).
REQ-029 After last sprite (spr_sel==NUM_SPRITES-1) evaluated, next state SHALL be DRAIN.
REQ-030 DRAIN: out_valid=1 iff read pointer<count; out_sel/out_line show entry at read pointer; out_valid&&out_ready advances pointer by one per cycle.
REQ-031 out_valid SHALL be 0 in IDLE and SCAN; entries not consumable before scan completes.
REQ-032 DRAIN with read pointer==count (including count==0) SHALL pulse done for one cycle and go to IDLE in that same cycle.
REQ-033 busy SHALL be 1 in SCAN and DRAIN, 0 in IDLE; busy and done never both 1.
REQ-034 out_ready ignored when out_valid=0; start simultaneous with out_ready handshake: start wins, no pop.
REQ-035 count, overflow SHALL remain stable in IDLE until next start.

Reset
REQ-036 reset SHALL force state=IDLE, spr_sel=0, count=0, read pointer=0, overflow=0, out_valid=0, busy=0, done=0; out_sel=0, out_line=0; overrides start in same cycle.
REQ-037 reset mid-SCAN or mid-DRAIN SHALL discard list, no done pulse.

Verification
REQ-038 vline=25, sprite 3 {y=10,en,h16=0}, sprite 7 {y=5,en,h16=1,vflip}, others disabled, out_ready=1 -> after 64 SCAN cycles, entries (3,line 0) then (7,line 10), count=2, done after 2 pops, overflow=0.
REQ-039 All 64 sprites enabled y=0 h16=0, vline=15 -> count=16, entries sel 0..15 line 0, overflow=1, scan still 64 cycles.
REQ-040 Sprite 0 {y=250,en,h16=1}, vline=19 (line_idx 4) -> hit, out_line=10; vline=14 (line_idx 255) -> out_line=5; line_idx 250-16=234 -> no hit.
REQ-041 No enabled sprites -> count=0, out_valid never 1, done pulse first DRAIN cycle, busy low next.
REQ-042 out_ready toggled 1/0 during drain of 3 entries -> each entry presented until accepted, exactly 3 pops; second start mid-drain -> list cleared, no done, new scan from sprite 0.
REQ-043 reset asserted in SCAN cycle 20 -> all outputs at reset values next cycle; later start operates normally.
